// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that lets N_REQ requesters share one FIFO write port.
// A grant is held until the grantee drops valid or its beat allowance is used up.
// The FSM always passes through IDLE between grants.
//
// Parameters
//   BITLEN     data width of each requester and of the FIFO write port
//   N_REQ      number of requesters (2..8)
//   BURST_LEN  maximum beats per grant when bursts are compiled in (1..15)
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   req_valid   per-requester data valid
//   req_data    per-requester data, requester i at [i*BITLEN +: BITLEN]
//   req_ready   per-requester accept (only the grantee, only when FIFO not full)
//   fifo_full   full flag from the shared FIFO
//   fifo_wr_en  FIFO write strobe (zero-latency pass-through of the grantee)
//   fifo_din    FIFO write data
//   grant_id    current grantee, meaningful while busy is high
//   busy        high while a grant is active
//   beat_total  free-running count of beats written, wraps at 2^32
//
// Build option
//   FIFO_ARB_BURST_EN  when defined, a grant may carry up to BURST_LEN beats;
//                      otherwise every grant carries exactly one beat.

module fifo_wr_arbiter #(
  parameter int BITLEN    = 64,
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*BITLEN-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [BITLEN-1:0]         fifo_din,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic [31:0]               beat_total
);

  localparam int IdW = $clog2(N_REQ);

`ifdef FIFO_ARB_BURST_EN
  localparam int BeatLimit = BURST_LEN;
`else
  // Without bursts every grant is a single beat, whatever BURST_LEN says.
  localparam int BeatLimit = (BURST_LEN > 0) ? 1 : 1;
`endif

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q;
  logic [IdW-1:0]   rrPtr_q;
  logic [IdW-1:0]   grantId_q;
  logic [3:0]       beatCnt_q;
  logic [31:0]      beatTotal_q;

  logic [IdW-1:0]   winner_d;
  logic [IdW-1:0]   rrPtr_d;
  logic [IdW-1:0]   cand;
  logic             grantOpen;
  logic             lastBeat;

  // Scan from the furthest offset back to rr_ptr so the last hit, i.e. the
  // first valid requester at or above rr_ptr (modulo N_REQ), is the winner.
  always_comb begin
    winner_d = '0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IdW'((int'(rrPtr_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        winner_d = cand;
      end
    end
  end

  assign rrPtr_d = (winner_d == IdW'(N_REQ - 1)) ? '0 : winner_d + 1'b1;

  // Ready is withheld during reset so an aborted grant never writes.
  assign grantOpen = (state_q == GRANT) & rst_n & ~fifo_full;

  always_comb begin
    req_ready = '0;
    if (grantOpen) begin
      req_ready[grantId_q] = 1'b1;
    end
  end

  assign fifo_wr_en = req_valid[grantId_q] & req_ready[grantId_q];
  assign fifo_din   = req_data[int'(grantId_q)*BITLEN +: BITLEN];

  // True when the beat being written now uses up the grant's allowance.
  assign lastBeat = ({1'b0, beatCnt_q} + 5'd1) == 5'(BeatLimit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      grantId_q   <= '0;
      beatCnt_q   <= '0;
      beatTotal_q <= '0;
    end else begin
      if (fifo_wr_en) begin
        beatTotal_q <= beatTotal_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          beatCnt_q <= '0;
          if (|req_valid) begin
            state_q   <= GRANT;
            grantId_q <= winner_d;
            rrPtr_q   <= rrPtr_d;
          end
        end
        GRANT: begin
          // A stalled grant (fifo_full) just waits; only a valid drop or the
          // final beat of the allowance ends it.
          if (!req_valid[grantId_q] || (fifo_wr_en && lastBeat)) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
          end else if (fifo_wr_en) begin
            beatCnt_q <= beatCnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_id   = grantId_q;
  assign busy       = (state_q == GRANT);
  assign beat_total = beatTotal_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter with a transaction-level reference
// model (grant owner, beats used, round-robin pointer, running total).

module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 64;
  localparam int BURST = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int BL = BURST;
`else
  localparam int BL = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_din;
  logic [1:0]     grant_id;
  logic           busy;
  logic [31:0]    beat_total;

  int nTests = 0;
  int nFail  = 0;

  // Reference model state
  bit          mBusy = 1'b0;
  int          mGrant = 0;
  int          mPtr = 0;
  int          mBeats = 0;
  logic [31:0] mTotal = '0;

  // Current cycle stimulus and predicted outputs
  logic [W-1:0] lane [N];
  logic [N-1:0] curV = '0;
  logic         curFull = 1'b0;
  logic         curRst = 1'b0;
  logic [N-1:0] expReady;
  logic         expWr;
  logic         expBusy;
  logic [W-1:0] expDin;
  int           expGrant;
  logic [31:0]  expTotal;

  fifo_wr_arbiter #(.BITLEN(W), .N_REQ(N), .BURST_LEN(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy),
    .beat_total (beat_total)
  );

  always #5 clk = ~clk;

  function automatic int rrWinner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // Drive one cycle of inputs after the falling edge and predict the outputs.
  task automatic applyStimulus(input logic [N-1:0] v, input logic full, input logic rstn);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      lane[i] = {$urandom(), $urandom()};
      req_data[i*W +: W] = lane[i];
    end
    req_valid = v;
    fifo_full = full;
    rst_n     = rstn;
    curV      = v;
    curFull   = full;
    curRst    = rstn;
    expBusy   = mBusy;
    expGrant  = mGrant;
    expTotal  = mTotal;
    expReady  = '0;
    expWr     = 1'b0;
    if (mBusy && rstn && !full) begin
      expReady[mGrant] = 1'b1;
      expWr = v[mGrant];
    end
    expDin = lane[mGrant];
    #2;
  endtask

  // Clock edge: move the reference model forward one cycle.
  task automatic advance();
    @(posedge clk);
    if (!curRst) begin
      mBusy = 1'b0; mGrant = 0; mPtr = 0; mBeats = 0; mTotal = '0;
    end else if (!mBusy) begin
      if (curV != '0) begin
        mGrant = rrWinner(curV, mPtr);
        mPtr   = (mGrant + 1) % N;
        mBusy  = 1'b1;
        mBeats = 0;
      end
    end else begin
      if (expWr) begin
        mTotal = mTotal + 32'd1;
        mBeats++;
      end
      if (!curV[mGrant] || mBeats == BL) begin
        mBusy  = 1'b0;
        mBeats = 0;
      end
    end
    #1;
  endtask

  task automatic settle();
    applyStimulus('0, 1'b0, 1'b1); advance();
    applyStimulus('0, 1'b0, 1'b1); advance();
  endtask

  task automatic test_reset();
    int order;
    applyStimulus('0, 1'b0, 1'b0); advance();
    applyStimulus('0, 1'b0, 1'b0); advance();
    applyStimulus('0, 1'b0, 1'b1);
    nTests++;
    if ({busy, fifo_wr_en, req_ready} !== 6'b0 || beat_total !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL reset_state: busy=%b wr=%b ready=%b total=%0d, want all 0", busy, fifo_wr_en, req_ready, beat_total);
    end
    advance();
    for (int c = 0; c < 10; c++) begin
      applyStimulus('1, 1'b0, 1'b1);
      nTests++;
      if (req_ready !== expReady || fifo_wr_en !== expWr || busy !== expBusy) begin
        nFail++;
        $display("[TB] FAIL rr_model c%0d: ready=%b wr=%b busy=%b, want %b %b %b", c, req_ready, fifo_wr_en, busy, expReady, expWr, expBusy);
      end
`ifndef FIFO_ARB_BURST_EN
      order = ((c - 1) / 2) % N;
      nTests++;
      if (fifo_wr_en !== logic'(c % 2 == 1) || (c % 2 == 1 && grant_id !== 2'(order))) begin
        nFail++;
        $display("[TB] FAIL rr_order c%0d: wr=%b grant=%0d, want wr=%b grant=%0d", c, fifo_wr_en, grant_id, c % 2 == 1, order);
      end
`endif
      if (expWr) begin
        nTests++;
        if (fifo_din !== expDin) begin
          nFail++;
          $display("[TB] FAIL rr_din c%0d: din=%h want %h", c, fifo_din, expDin);
        end
      end
      advance();
    end
  endtask

  task automatic test_burst();
    int written = 0, run = 0, gap = 0, groups = 0, doneBefore = 0, want;
    logic [31:0] startTotal;
    settle();
    startTotal = mTotal;
    for (int c = 0; c < 80 && !(written == 10 && run == 0 && !mBusy); c++) begin
      applyStimulus((written < 10) ? 4'b0100 : 4'b0000, 1'b0, 1'b1);
      nTests++;
      if (fifo_wr_en !== expWr || busy !== expBusy || req_ready !== expReady || (expWr && fifo_din !== expDin)) begin
        nFail++;
        $display("[TB] FAIL burst_model c%0d: wr=%b busy=%b ready=%b din=%h, want %b %b %b %h", c, fifo_wr_en, busy, req_ready, fifo_din, expWr, expBusy, expReady, expDin);
      end
      if (fifo_wr_en === 1'b1) begin
        if (run == 0 && groups > 0) begin
          nTests++;
          if (gap !== 1) begin
            nFail++;
            $display("[TB] FAIL burst_gap: gap=%0d cycles, want 1", gap);
          end
        end
        run++;
        gap = 0;
      end else begin
        if (run != 0) begin
          want = (10 - doneBefore < BL) ? 10 - doneBefore : BL;
          nTests++;
          if (run !== want) begin
            nFail++;
            $display("[TB] FAIL burst_group%0d: beats=%0d, want %0d", groups, run, want);
          end
          doneBefore += run;
          groups++;
          run = 0;
        end
        gap++;
      end
      if (expWr) written++;
      advance();
    end
    nTests++;
    if (groups !== (10 + BL - 1) / BL || beat_total !== startTotal + 32'd10) begin
      nFail++;
      $display("[TB] FAIL burst_total: groups=%0d total=%0d, want %0d %0d", groups, beat_total, (10 + BL - 1) / BL, startTotal + 32'd10);
    end
  endtask

  task automatic test_full_stall();
    settle();
    applyStimulus(4'b1000, 1'b0, 1'b1); advance();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1000, 1'b1, 1'b1);
      nTests++;
      if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd3) begin
        nFail++;
        $display("[TB] FAIL stall k%0d: wr=%b ready=%b busy=%b grant=%0d, want 0 0000 1 3", k, fifo_wr_en, req_ready, busy, grant_id);
      end
      advance();
    end
    applyStimulus(4'b1000, 1'b0, 1'b1);
    nTests++;
    if (fifo_wr_en !== 1'b1 || req_ready !== 4'b1000 || fifo_din !== lane[3]) begin
      nFail++;
      $display("[TB] FAIL stall_resume: wr=%b ready=%b din=%h, want 1 1000 %h", fifo_wr_en, req_ready, fifo_din, lane[3]);
    end
    advance();
  endtask

  task automatic test_valid_drop();
    logic [N-1:0] pattern [6];
    int prevG = -1, nextAfter1 = -1;
    pattern = '{4'b0010, 4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0100};
    settle();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(pattern[c], 1'b0, 1'b1);
      nTests++;
      if (fifo_wr_en !== expWr || busy !== expBusy || (expBusy && grant_id !== 2'(expGrant))) begin
        nFail++;
        $display("[TB] FAIL drop_model c%0d: wr=%b busy=%b grant=%0d, want %b %b %0d", c, fifo_wr_en, busy, grant_id, expWr, expBusy, expGrant);
      end
`ifdef FIFO_ARB_BURST_EN
      if (c == 3 || c == 4) begin
        nTests++;
        if (busy !== logic'(c == 3) || fifo_wr_en !== 1'b0) begin
          nFail++;
          $display("[TB] FAIL drop_idle c%0d: busy=%b wr=%b, want %b 0", c, busy, fifo_wr_en, c == 3);
        end
      end
`endif
      if (busy === 1'b1) begin
        if (prevG == 1 && grant_id != 2'd1 && nextAfter1 < 0) nextAfter1 = int'(grant_id);
        prevG = int'(grant_id);
      end
      advance();
    end
    nTests++;
    if (nextAfter1 !== 2) begin
      nFail++;
      $display("[TB] FAIL drop_next: next grantee=%0d, want 2", nextAfter1);
    end
  endtask

  task automatic test_reset_mid_grant();
    settle();
    applyStimulus(4'b0100, 1'b1, 1'b1); advance();
    applyStimulus(4'b0100, 1'b1, 1'b1);
    nTests++;
    if (busy !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL rstmid_busy: busy=%b want 1", busy);
    end
    advance();
    applyStimulus(4'b0100, 1'b0, 1'b0);
    nTests++;
    if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin
      nFail++;
      $display("[TB] FAIL rstmid_nowrite: wr=%b ready=%b, want 0 0000", fifo_wr_en, req_ready);
    end
    advance();
    applyStimulus(4'b1111, 1'b0, 1'b1);
    nTests++;
    if (busy !== 1'b0 || beat_total !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL rstmid_after: busy=%b total=%0d, want 0 0", busy, beat_total);
    end
    advance();
    applyStimulus(4'b1111, 1'b0, 1'b1);
    nTests++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_wr_en !== 1'b1 || fifo_din !== lane[0]) begin
      nFail++;
      $display("[TB] FAIL rstmid_rr: busy=%b grant=%0d wr=%b, want 1 0 1", busy, grant_id, fifo_wr_en);
    end
    advance();
  endtask

  task automatic test_wrap();
    settle();
    applyStimulus('0, 1'b0, 1'b1);
    force dut.beatTotal_q = 32'hFFFF_FFFF;
    advance();
    release dut.beatTotal_q;
    mTotal = 32'hFFFF_FFFF;
    applyStimulus(4'b0001, 1'b0, 1'b1);
    nTests++;
    if (beat_total !== 32'hFFFF_FFFF) begin
      nFail++;
      $display("[TB] FAIL wrap_preload: total=%h want ffffffff", beat_total);
    end
    advance();
    applyStimulus(4'b0001, 1'b0, 1'b1);
    nTests++;
    if (fifo_wr_en !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL wrap_write: wr=%b want 1", fifo_wr_en);
    end
    advance();
    applyStimulus('0, 1'b0, 1'b1);
    nTests++;
    if (beat_total !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL wrap_total: total=%h want 0", beat_total);
    end
    advance();
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic full, rstn;
    settle();
    for (int c = 0; c < 400; c++) begin
      v    = N'($urandom_range(0, 15));
      full = ($urandom_range(0, 3) == 0);
      rstn = ($urandom_range(0, 49) != 0);
      applyStimulus(v, full, rstn);
      nTests++;
      if (req_ready !== expReady || fifo_wr_en !== expWr || busy !== expBusy || beat_total !== expTotal
          || (expBusy && grant_id !== 2'(expGrant)) || (expWr && fifo_din !== expDin)) begin
        nFail++;
        $display("[TB] FAIL random c%0d: ready=%b wr=%b busy=%b grant=%0d total=%0d, want %b %b %b %0d %0d",
                 c, req_ready, fifo_wr_en, busy, grant_id, beat_total, expReady, expWr, expBusy, expGrant, expTotal);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_grant();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: BITLEN, default 64, data width of each requester and of the FIFO write port.
REQ-002 Parameter: N_REQ, default 4, number of requesters, 2..8.
REQ-003 Parameter: BURST_LEN, default 4, maximum beats per grant when the burst feature is compiled in, 1..15.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 req_valid  input  N_REQ  per-requester data valid.
REQ-007 req_data  input  N_REQ*BITLEN  per-requester data; requester i occupies bits [i*BITLEN +: BITLEN].
REQ-008 req_ready  output  N_REQ  per-requester accept; a beat transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 fifo_full  input  1  full flag from the shared FIFO.
REQ-010 fifo_wr_en  output  1  FIFO write strobe.
REQ-011 fifo_din  output  BITLEN  FIFO write data.
REQ-012 grant_id  output  clog2(N_REQ)  index of the current grantee; meaningful only while busy is high.
REQ-013 busy  output  1  high while in GRANT.
REQ-014 beat_total  output  32  count of beats written to the FIFO; wraps modulo 2^32.

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 In IDLE, when any req_valid bit is high, the block SHALL register a round-robin winner into grant_id and enter GRANT on the next edge. No data transfers in IDLE.
REQ-017 Round-robin search SHALL start at rr_ptr and proceed upward modulo N_REQ; the first requester with req_valid high wins.
REQ-018 On entering GRANT, rr_ptr SHALL become (winner+1) mod N_REQ.
REQ-019 req_ready[i] SHALL be combinational: (state==GRANT) & (i==grant_id) & ~fifo_full. All other ready bits SHALL be 0.
REQ-020 fifo_wr_en SHALL be combinational: req_valid[grant_id] & req_ready[grant_id]. fifo_din SHALL equal req_data of grant_id, so write latency is zero cycles.
REQ-021 fifo_full high in GRANT SHALL stall: no write, grant held, no timeout.
REQ-022 A req_valid[grant_id] low cycle in GRANT SHALL return the FSM to IDLE on the next edge.
REQ-023 Each fifo_wr_en cycle SHALL increment beat_cnt (4 bits) and beat_total; beat_cnt SHALL clear on entering IDLE.
REQ-024 When the current grantee writes in the same edge that another requester asserts req_valid, the new request is serviced only after the return to IDLE; requests are never pre-empted.
REQ-025 There SHALL be at least one IDLE cycle between consecutive grants, including back-to-back requests from the same requester.

Reset
REQ-026 When rst_n is low at a clock edge, the block SHALL set state to IDLE, rr_ptr to 0, grant_id to 0, beat_cnt to 0 and beat_total to 0.
REQ-027 While the block is in IDLE after reset, req_ready and fifo_wr_en SHALL be 0. Reset asserted mid-grant SHALL abort the grant; no write occurs at that edge.

Configuration
REQ-028 Macro FIFO_ARB_BURST_EN. When it is defined, GRANT SHALL end after the edge on which beat_cnt reaches BURST_LEN, or per REQ-022.
REQ-029 When FIFO_ARB_BURST_EN is undefined, GRANT SHALL end after exactly one written beat, so BURST_LEN is ignored.

Verification
REQ-030 Test 1, reset: reset, then all 4 requesters valid continuously with no burst macro. Required grant order is 0,1,2,3,0, one beat each, with fifo_wr_en high on every second cycle.
REQ-031 Test 2, burst: with FIFO_ARB_BURST_EN and BURST_LEN=4, requester 2 sends 10 beats. Required: writes in groups of 4, 4 and 2, an IDLE cycle between groups, and beat_total=10.
REQ-032 Test 3, full stall: fifo_full is held high for 5 cycles during a grant. Required: no fifo_wr_en, req_ready all 0, grant_id unchanged; the write resumes on the first cycle fifo_full is low.
REQ-033 Test 4, valid drop: requester 1 drops valid after 2 of 4 burst beats. Required: return to IDLE; the next grant goes to requester 2 if it is valid.
REQ-034 Test 5, reset mid-grant: rst_n low while busy=1. Required: busy=0 next cycle, beat_total=0, and requester 0 wins the next arbitration.
REQ-035 Test 6, wrap: preload beat_total to 0xFFFFFFFF via force, then write 1 beat. Required: beat_total=0.
